// File: rtl/fixed_point_mac.sv
// fixed_point_mac: pipelined signed fixed-point multiply-accumulate.
// One saturated dot-product per first..last framed operand stream.
// Stages: S0 operand capture, S1 product, S2 accumulator, S3 rescale/clamp.
// Build option: define ROUND_EN for round-half-up in S3 (default truncates).
module fixed_point_mac #(
  parameter int WIDTH = 23,
  parameter int FRAC  = 14,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             first,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  localparam int PW    = 2*WIDTH;
  localparam int ACC_W = PW + GUARD;
  localparam int RW    = ACC_W - FRAC;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // Symmetric output range: +/-(2^(WIDTH-1)-1), sign-extended to RW bits
  localparam logic [RW-1:0] RMAX = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [RW-1:0] RMIN = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-2){1'b0}}, 1'b1};

  // Stage valids: [1]=S0, [2]=S1, [3]=S2; S3 valid is out_valid itself
  logic [3:1]       vld_q;
  logic             en;

  logic [WIDTH-1:0] a_q, b_q;
  logic             first0_q, last0_q;
  logic [PW-1:0]    prod_d, prod_q;
  logic             first1_q, last1_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             sticky_d, sticky_q, last2_q;
  logic             out_valid_q, sat_q, sat_d;
  logic [WIDTH-1:0] y_q, y_d;

  // Whole pipeline advances together; it only freezes behind an unaccepted result
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign sat       = sat_q;

  // S0: register operands so the multiplier sees clean flop outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q[1] <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      first0_q <= 1'b0;
      last0_q  <= 1'b0;
    end else if (en) begin
      vld_q[1] <= in_valid;
      if (in_valid) begin
        a_q      <= a;
        b_q      <= b;
        first0_q <= first;
        last0_q  <= last;
      end
    end
  end

  // Full-width signed product: sign-extend both operands, keep low PW bits
  logic [PW-1:0] a_ext, b_ext;
  assign a_ext  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext  = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_d = a_ext * b_ext;

  // S1: product register with frame flags alongside
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q[2] <= 1'b0;
      prod_q   <= '0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else if (en) begin
      vld_q[2] <= vld_q[1];
      if (vld_q[1]) begin
        prod_q   <= prod_d;
        first1_q <= first0_q;
        last1_q  <= last0_q;
      end
    end
  end

  // S2 next state: load on first, otherwise saturating add with sticky overflow
  logic [ACC_W-1:0] p_ext, acc_add;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf;
  always_comb begin
    p_ext    = {{GUARD{prod_q[PW-1]}}, prod_q};
    acc_sum  = {acc_q[ACC_W-1], acc_q} + {p_ext[ACC_W-1], p_ext};
    acc_ovf  = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    acc_add  = acc_ovf ? (acc_sum[ACC_W] ? ACC_MIN : ACC_MAX) : acc_sum[ACC_W-1:0];
    acc_d    = first1_q ? p_ext : acc_add;
    sticky_d = first1_q ? 1'b0 : (sticky_q | acc_ovf);
  end

  // S2: accumulator register, updated only by valid beats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q[3] <= 1'b0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      last2_q  <= 1'b0;
    end else if (en) begin
      vld_q[3] <= vld_q[2];
      if (vld_q[2]) begin
        acc_q    <= acc_d;
        sticky_q <= sticky_d;
        last2_q  <= last1_q;
      end
    end
  end

  // S3 datapath: optional rounding, arithmetic shift by FRAC, symmetric clamp
  logic [ACC_W-1:0] racc;
  logic [RW-1:0]    r;
  logic             hi, lo;
  logic             unused_lsb;
`ifdef ROUND_EN
  localparam logic [ACC_W:0] HALF = {{(ACC_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  logic [ACC_W:0] rsum;
  // Adding a positive constant can only overflow upward, so clamp to max
  always_comb begin
    rsum = {acc_q[ACC_W-1], acc_q} + HALF;
    racc = (rsum[ACC_W] ^ rsum[ACC_W-1]) ? ACC_MAX : rsum[ACC_W-1:0];
  end
`else
  assign racc = acc_q;
`endif
  assign r          = racc[ACC_W-1:FRAC];
  assign unused_lsb = ^racc[FRAC-1:0];

  // Clamp decision and result/flag formation
  always_comb begin
    hi    = $signed(r) > $signed(RMAX);
    lo    = $signed(r) < $signed(RMIN);
    y_d   = hi ? RMAX[WIDTH-1:0] : (lo ? RMIN[WIDTH-1:0] : r[WIDTH-1:0]);
    sat_d = hi | lo | sticky_q;
  end

  // S3: output register; result held while stalled, valid drops once taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= vld_q[3] & last2_q;
      if (vld_q[3] && last2_q) begin
        y_q   <= y_d;
        sat_q <= sat_d;
      end
    end
  end

endmodule

// File: doc/fixed_point_mac.md
Name: fixed_point_mac

Overview:
Pipelined, parametrised signed fixed-point multiply-accumulate unit with symmetric saturation to the WIDTH-bit Q format.
Accepts a stream of (a, b) operand pairs framed by first/last flags and emits one saturated dot-product per frame.
Uses valid/ready handshakes on both sides.
Sits between the sample/coefficient sources and the controller/filter datapath; a single-beat frame replaces the stand-alone fixed-point multiplier.

Parameters:
WIDTH, 23, total operand/result width, two's complement
FRAC, 14, fractional bits (Q(WIDTH-FRAC-1).FRAC)
GUARD, 4, accumulator guard bits; frames of up to 2^GUARD beats are exact

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
a  input  WIDTH  signed operand A
b  input  WIDTH  signed operand B
first  input  1  beat starts a new frame (accumulator loads instead of adds)
last  input  1  beat ends the frame (result is produced)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
y  output  WIDTH  saturated, rescaled frame result
sat  output  1  y was clamped, or the accumulator clamped during this frame

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: out_valid=0, y=0, sat=0, in_ready=1 after reset release; all stage valids 0; accumulator 0.
- Pipeline enable: en = !out_valid || out_ready. When en=0, every stage holds its contents. in_ready = en (combinational).
- Beat accepted when in_valid && in_ready.
- S1 (product register): p = a*b, full 2*WIDTH signed. first/last/valid carried alongside.
- S2 (accumulator, ACC_W = 2*WIDTH+GUARD):
  - first=1: acc <= sext(p).
  - first=0: acc <= acc + sext(p).
  - If the add overflows ACC_W, acc clamps to ACC_W max/min and the frame's sticky saturation flag is set.
  - first clears the sticky flag.
- S3 (output register), on a last beat leaving S2:
  - r = acc >>> FRAC (arithmetic shift, truncation toward -inf).
  - r > 2^(WIDTH-1)-1 gives y = 2^(WIDTH-1)-1.
  - r < -(2^(WIDTH-1)-1) gives y = -(2^(WIDTH-1)-1). The range is symmetric; the most-negative code is never produced.
  - Otherwise y = r[WIDTH-1:0].
  - sat = clamp OR sticky flag. out_valid <= 1.
- out_valid clears on out_ready && !(new result arriving). y and sat stay stable while out_valid && !out_ready.
- Latency: a last beat accepted at edge T gives out_valid=1 after edge T+3 with en held high. Throughput is 1 beat/cycle.
- A zero operand needs no special case: the product is 0 and the result is exact.
- first && last on the same beat: single multiply, y = sat((a*b)>>>FRAC).
- A beat with first=0 after a completed frame (no first): accumulation continues from the stale acc. This is legal but undefined-use; the bench does not check it.
- reset_n low mid-frame or mid-stall: all state is dropped immediately, and any partial frame is lost.

Optional Feature:
ROUND_EN
- Defined: S3 adds 2^(FRAC-1) to acc (saturating in ACC_W) before the shift, giving round-half-up, then clamps as above.
- Undefined: truncation only, with no adder in S3.
- Latency is unchanged in both builds.

Test Plan:
- Single beat, first=last=1, a=24576 (1.5), b=32768 (2.0) -> y=49152 (3.0), sat=0, out_valid exactly 3 cycles after acceptance.
- a=3276800 (200.0), b=32768 (2.0), single beat -> y=4194303, sat=1. Same with a=-3276800 -> y=-4194303, sat=1.
- 4-beat frame, each a=16384 (1.0), b=8192 (0.5), first on beat 0, last on beat 3, back-to-back -> one result y=32768 (2.0), sat=0. Next frame starts cleanly.
- Backpressure: out_ready=0 for 5 cycles with beats offered -> in_ready=0 from the cycle out_valid=1, y held stable, no beat lost. Releasing out_ready drains the results in order.
- a=1, b=8192, single beat -> y=0 without ROUND_EN, y=1 with ROUND_EN. a=-1, b=8192 -> y=-1 without ROUND_EN, y=0 with ROUND_EN.
- Assert reset_n=0 asynchronously mid-frame (2 of 4 beats in) -> out_valid=0, y=0, sat=0 immediately. A fresh frame after release gives the correct result unaffected by the dropped beats.
